// File: rtl/block_completion_tracker_pkg.sv
// Shared types and defaults for the TRIPS block completion tracker.
package block_completion_tracker_pkg;

  localparam int MAX_INFLIGHT_BLOCKS = 8;
  localparam int LSID_W              = 5;
  localparam int EXIT_W              = 5;

  // Only the fields the tracker consumes from a block header.
  typedef struct packed {
    logic [31:0]       store_mask;
    logic [4:0]        num_reg_writes;
  } block_header_t;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    ACTIVE   = 2'd1,
    COMPLETE = 2'd2
  } bct_slot_state_t;

  // Everything one in-flight block slot remembers.
  typedef struct packed {
    bct_slot_state_t   state;
    logic [31:0]       store_mask;
    logic [31:0]       stores_seen;
    logic [4:0]        num_reg_writes;
    logic [4:0]        wr_cnt;
    logic              br_seen;
    logic [EXIT_W-1:0] exit_id;
  } bct_slot_t;

endpackage

// File: rtl/block_completion_tracker_slot.sv
// One in-flight block slot: collects store/write/branch arrivals and
// reports when the block's outputs are all present.
module bct_slot
  import block_completion_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_alloc,
  input  block_header_t     i_header,
  input  logic              i_free,
  input  logic              i_storeValid,
  input  logic [LSID_W-1:0] i_storeLsid,
  input  logic              i_wrValid,
  input  logic              i_brValid,
  input  logic [EXIT_W-1:0] i_brExitId,
  output bct_slot_state_t   o_state,
  output logic [EXIT_W-1:0] o_exitId,
  output logic              o_complete,
  output logic              o_err
);

  bct_slot_t         r_slot;
  bct_slot_t         w_slotNext;
  logic              w_active;
  logic              w_storeBad;
  logic              w_wrBad;
  logic              w_brBad;
  logic              w_storeOk;
  logic              w_wrOk;
  logic              w_brOk;
  logic [31:0]       w_seenNext;
  logic [4:0]        w_wrCntNext;
  logic              w_brSeenNext;
  logic              w_doneNext;

  // Classify incoming events and form the post-update counters used for completion.
  always_comb begin
    w_active     = (r_slot.state == ACTIVE);
    w_storeBad   = i_storeValid && (!r_slot.store_mask[i_storeLsid] ||
                                    r_slot.stores_seen[i_storeLsid]);
    w_wrBad      = i_wrValid && (r_slot.wr_cnt == r_slot.num_reg_writes);
    w_brBad      = i_brValid && r_slot.br_seen;
    w_storeOk    = i_storeValid && w_active && !w_storeBad;
    w_wrOk       = i_wrValid && w_active && !w_wrBad;
    w_brOk       = i_brValid && w_active && !w_brBad;
    w_seenNext   = r_slot.stores_seen | (w_storeOk ? (32'd1 << i_storeLsid) : 32'd0);
    w_wrCntNext  = r_slot.wr_cnt + (w_wrOk ? 5'd1 : 5'd0);
    w_brSeenNext = r_slot.br_seen | w_brOk;
    w_doneNext   = (w_seenNext == r_slot.store_mask) &&
                   (w_wrCntNext == r_slot.num_reg_writes) && w_brSeenNext;
  end

  // Next slot contents: free/flush wins over a new mapping, which wins over events.
  always_comb begin
    w_slotNext = r_slot;
    if (i_free) begin
      w_slotNext = '0;
    end else if (i_alloc) begin
      w_slotNext                = '0;
      w_slotNext.state          = ACTIVE;
      w_slotNext.store_mask     = i_header.store_mask;
      w_slotNext.num_reg_writes = i_header.num_reg_writes;
    end else if (w_active) begin
      w_slotNext.stores_seen = w_seenNext;
      w_slotNext.wr_cnt      = w_wrCntNext;
      w_slotNext.br_seen     = w_brSeenNext;
      w_slotNext.exit_id     = w_brOk ? i_brExitId : r_slot.exit_id;
      if (w_doneNext) begin
        w_slotNext.state = COMPLETE;
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
    end else begin
      r_slot <= w_slotNext;
    end
  end

  // Status outputs; any event to a non-ACTIVE slot or a malformed event is an error.
  always_comb begin
    o_state    = r_slot.state;
    o_exitId   = r_slot.exit_id;
    o_complete = (r_slot.state == COMPLETE);
    o_err      = (i_storeValid || i_wrValid || i_brValid) &&
                 (!w_active || w_storeBad || w_wrBad || w_brBad);
  end

endmodule

// File: rtl/block_completion_tracker.sv
// Tracks completion of every in-flight TRIPS block and hands commits to the
// G-tile block controller strictly in program order.
module block_completion_tracker
  import block_completion_tracker_pkg::*;
#(
  parameter int NUM_SLOTS = MAX_INFLIGHT_BLOCKS,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  block_header_t        alloc_header,
  output logic [SLOT_W-1:0]    alloc_tag,
  input  logic                 store_valid,
  input  logic [SLOT_W-1:0]    store_tag,
  input  logic [LSID_W-1:0]    store_lsid,
  input  logic                 wr_valid,
  input  logic [SLOT_W-1:0]    wr_tag,
  input  logic                 br_valid,
  input  logic [SLOT_W-1:0]    br_tag,
  input  logic [EXIT_W-1:0]    br_exit_id,
  input  logic                 flush_valid,
  input  logic [SLOT_W-1:0]    flush_tag,
  output logic                 commit,
  output logic [SLOT_W-1:0]    commit_tag,
  output logic [EXIT_W-1:0]    commit_exit_id,
  input  logic                 commit_ack,
  output logic [NUM_SLOTS-1:0] inflight_blocks,
  output logic                 protocol_err
);

  localparam logic [SLOT_W:0] LP_FULL = (SLOT_W+1)'(NUM_SLOTS);

  logic [SLOT_W-1:0]    r_head;
  logic [SLOT_W-1:0]    r_tail;
  logic [SLOT_W:0]      r_count;
  logic                 r_protocolErr;

  logic [NUM_SLOTS-1:0] w_slotComplete;
  logic [NUM_SLOTS-1:0] w_slotInflight;
  logic [NUM_SLOTS-1:0] w_slotErr;
  logic [NUM_SLOTS-1:0] w_kill;
  logic [NUM_SLOTS-1:0] w_slotFree;
  logic [NUM_SLOTS-1:0] w_slotAlloc;
  logic [EXIT_W-1:0]    w_slotExit   [NUM_SLOTS];
  logic [SLOT_W-1:0]    w_slotOffset [NUM_SLOTS];
  logic [SLOT_W-1:0]    w_flushOffset;
  logic                 w_flushOk;
  logic                 w_allocFire;
  logic                 w_commitFire;

  // Handshakes, head commit mux and flush range check; a flush that squashes the head drops its ack.
  always_comb begin
    alloc_ready     = (r_count != LP_FULL) && !flush_valid;
    alloc_tag       = r_tail;
    commit          = w_slotComplete[r_head];
    commit_tag      = r_head;
    commit_exit_id  = w_slotExit[r_head];
    inflight_blocks = w_slotInflight;
    protocol_err    = r_protocolErr;
    w_allocFire     = alloc_valid && alloc_ready;
    w_flushOffset   = flush_tag - r_head;
    w_flushOk       = flush_valid && ({1'b0, w_flushOffset} < r_count);
    w_commitFire    = commit && commit_ack && !(w_flushOk && (flush_tag == r_head));
  end

  // Per-slot strobes: squash everything from flush_tag up to the tail, free the committed head, map the tail.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_slotOffset[i] = SLOT_W'(i) - r_head;
      w_kill[i]       = w_flushOk && (w_slotOffset[i] >= w_flushOffset) &&
                        ({1'b0, w_slotOffset[i]} < r_count);
      w_slotFree[i]   = w_kill[i] || (w_commitFire && (r_head == SLOT_W'(i)));
      w_slotAlloc[i]  = w_allocFire && (r_tail == SLOT_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bct_slot_state_t w_state;

    bct_slot u_slot (
      .clk          (clk),
      .rst          (rst),
      .i_alloc      (w_slotAlloc[g]),
      .i_header     (alloc_header),
      .i_free       (w_slotFree[g]),
      .i_storeValid (store_valid && (store_tag == SLOT_W'(g)) && !w_kill[g]),
      .i_storeLsid  (store_lsid),
      .i_wrValid    (wr_valid && (wr_tag == SLOT_W'(g)) && !w_kill[g]),
      .i_brValid    (br_valid && (br_tag == SLOT_W'(g)) && !w_kill[g]),
      .i_brExitId   (br_exit_id),
      .o_state      (w_state),
      .o_exitId     (w_slotExit[g]),
      .o_complete   (w_slotComplete[g]),
      .o_err        (w_slotErr[g])
    );

    assign w_slotInflight[g] = (w_state != FREE);
  end

  // Queue pointers, occupancy and the sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_protocolErr <= 1'b0;
    end else begin
      if (w_commitFire) begin
        r_head <= r_head + 1'b1;
      end
      if (w_flushOk) begin
        r_tail  <= flush_tag;
        r_count <= {1'b0, w_flushOffset} - (SLOT_W+1)'(w_commitFire);
      end else begin
        r_tail  <= r_tail + SLOT_W'(w_allocFire);
        r_count <= r_count + (SLOT_W+1)'(w_allocFire) - (SLOT_W+1)'(w_commitFire);
      end
      if ((|w_slotErr) || (commit_ack && !commit) || (flush_valid && !w_flushOk)) begin
        r_protocolErr <= 1'b1;
      end
    end
  end

endmodule
